// File: rtl/mem_arbiter_ctrl_if.sv
// CPU-side and RAM-side signal bundle for the shared memory port arbiter.
// slave is the arbiter's view; master is the CPU/RAM environment's view.
interface mem_arbiter_ctrl_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates the single RAM port between instruction fetch and data access:
// registered grant with data priority, fetch starvation guard and ERROR retry.
module mem_arbiter_ctrl #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    mem_arbiter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic [1:0]       RAM_ACCESS = 2'd2;
    localparam logic [1:0]       RAM_ERROR  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STARVE_LIMIT);

    state_t           state;
    state_t           state_nxt;
    state_t           arb;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dreq;
    logic             serve_i;
    logic             serve_d;
    logic             done_i;
    logic             done_d;

    // Grant is only honoured while the owning request is still asserted.
    always_comb begin
        dreq    = bus.dREN | bus.dWEN;
        serve_i = (state == GRANT_I) && bus.iREN;
        serve_d = (state == GRANT_D) && dreq;
        done_i  = serve_i && (bus.ramstate == RAM_ACCESS);
        done_d  = serve_d && (bus.ramstate == RAM_ACCESS);
    end

    // Counter and arbitration use the post-update count so fetch wins right
    // after the STARVE_LIMIT-th consecutive data completion.
    always_comb begin
        cnt_nxt = cnt;
        if (done_d && bus.iREN) begin
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end else if (done_i || !bus.iREN) begin
            cnt_nxt = '0;
        end

        arb = IDLE;
        if (dreq && !(bus.iREN && (cnt_nxt == CNT_MAX))) begin
            arb = GRANT_D;
        end else if (bus.iREN) begin
            arb = GRANT_I;
        end

        state_nxt = state;
        if ((state == IDLE) || done_i || done_d) begin
            state_nxt = arb;
        end else if (!(serve_i || serve_d) || (bus.ramstate == RAM_ERROR)) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // RAM and requester outputs follow the grant and the live request lines.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        if (serve_i) begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr;
        end
        if (serve_d) begin
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = !bus.dWEN;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
        end
        if (done_i) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
        end
        if (done_d) begin
            bus.dwait = 1'b0;
            bus.dload = bus.dWEN ? 32'd0 : bus.ramload;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: directed scenarios plus randomized traffic
// against a transaction-level reference of the arbitration rules.
module tb_mem_arbiter_ctrl;

    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam int         LIMIT      = 4;

    logic CLK;
    logic nRST;
    int   total;
    int   bad;

    mem_arbiter_ctrl_if bus ();

    mem_arbiter_ctrl #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = RAM_FREE;
    endtask

    // Leaves the bench just after a falling edge, reset released, DUT idle.
    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nRST = 1'b0;
        clear_inputs();
        @(posedge CLK);
        @(negedge CLK);
        #2;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 4'b0011) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0011", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait});
        end
        total++;
        if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== 128'd0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {bus.ramaddr, bus.ramstore, bus.iload, bus.dload});
        end
        // requests during reset must not produce a grant
        @(negedge CLK);
        bus.iREN = 1'b1;
        bus.dREN = 1'b1;
        bus.ramstate = RAM_ACCESS;
        @(posedge CLK);
        @(negedge CLK);
        #2;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 4'b0011) begin
            bad++;
            $display("FAIL reset_with_req: got %b want 0011", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait});
        end
        clear_inputs();
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            #2;
            total++;
            if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 4'b0011) begin
                bad++;
                $display("FAIL idle_after_reset c%0d: got %b want 0011", c, {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait});
            end
        end
    endtask

    task automatic test_single_fetch();
        do_reset();
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h0000_0040;
        #2;
        total++;
        if ({bus.ramREN, bus.iwait} !== 2'b01) begin
            bad++;
            $display("FAIL fetch_latency: got %b want 01", {bus.ramREN, bus.iwait});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            bus.ramstate = (k < 2) ? RAM_BUSY : RAM_ACCESS;
            bus.ramload  = (k < 2) ? 32'h5555_AAAA : 32'h8C22_0004;
            #2;
            total++;
            if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== {2'b10, 32'h0000_0040}) begin
                bad++;
                $display("FAIL fetch_ram k%0d: got %b %h want 10 00000040", k, {bus.ramREN, bus.ramWEN}, bus.ramaddr);
            end
            total++;
            if (bus.iwait !== ((k == 2) ? 1'b0 : 1'b1) || bus.dwait !== 1'b1) begin
                bad++;
                $display("FAIL fetch_wait k%0d: got i=%b d=%b want i=%b d=1", k, bus.iwait, bus.dwait, k != 2);
            end
        end
        total++;
        if (bus.iload !== 32'h8C22_0004) begin
            bad++;
            $display("FAIL fetch_iload: got %h want 8c220004", bus.iload);
        end
        @(negedge CLK);
        bus.iREN = 1'b0;
        bus.ramstate = RAM_FREE;
        #2;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait} !== 3'b001) begin
            bad++;
            $display("FAIL fetch_release: got %b want 001", {bus.ramREN, bus.ramWEN, bus.iwait});
        end
    endtask

    task automatic test_contention();
        do_reset();
        bus.iREN = 1'b1;  bus.iaddr = 32'h80;
        bus.dREN = 1'b1;  bus.dWEN = 1'b1;
        bus.daddr = 32'h100;  bus.dstore = 32'hDEAD_BEEF;
        bus.ramstate = RAM_ACCESS;  bus.ramload = 32'hCAFE_F00D;
        @(negedge CLK);
        #2;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== {2'b01, 32'h100, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL contention_write: got %b %h %h want 01 00000100 deadbeef",
                     {bus.ramREN, bus.ramWEN}, bus.ramaddr, bus.ramstore);
        end
        total++;
        if ({bus.iwait, bus.dwait, bus.dload} !== {2'b10, 32'd0}) begin
            bad++;
            $display("FAIL contention_done: got i=%b d=%b dload=%h want i=1 d=0 dload=0", bus.iwait, bus.dwait, bus.dload);
        end
        // data still pending at completion keeps the port; then it withdraws
        @(negedge CLK);
        bus.dREN = 1'b0;  bus.dWEN = 1'b0;
        bus.ramstate = RAM_BUSY;
        #2;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 4'b0011) begin
            bad++;
            $display("FAIL contention_withdraw: got %b want 0011", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait});
        end
        @(negedge CLK);
        bus.ramstate = RAM_ACCESS;
        bus.ramload  = 32'h1111_2222;
        @(negedge CLK);
        #2;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.iload} !== {2'b10, 32'h80, 1'b0, 32'h1111_2222}) begin
            bad++;
            $display("FAIL contention_fetch: got %b %h i=%b %h want 10 00000080 i=0 11112222",
                     {bus.ramREN, bus.ramWEN}, bus.ramaddr, bus.iwait, bus.iload);
        end
        clear_inputs();
    endtask

    task automatic test_starvation();
        logic exp_i;
        logic exp_d;
        do_reset();
        bus.iREN = 1'b1;  bus.iaddr = 32'h600;
        bus.dREN = 1'b1;  bus.daddr = 32'h500;
        bus.ramstate = RAM_ACCESS;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge CLK);
            bus.ramload = $urandom;
            #2;
            exp_i = !(c == 5 || c == 10);
            exp_d = !(c inside {1, 2, 3, 4, 6, 7, 8, 9, 11});
            total++;
            if ({bus.iwait, bus.dwait} !== {exp_i, exp_d}) begin
                bad++;
                $display("FAIL starve_waits c%0d: got i=%b d=%b want i=%b d=%b", c, bus.iwait, bus.dwait, exp_i, exp_d);
            end
            if (c > 0) begin
                total++;
                if (bus.ramREN !== 1'b1 || bus.ramaddr !== (exp_i ? 32'h500 : 32'h600)) begin
                    bad++;
                    $display("FAIL starve_addr c%0d: got ren=%b %h want ren=1 %h", c, bus.ramREN, bus.ramaddr,
                             exp_i ? 32'h500 : 32'h600);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_error_retry();
        do_reset();
        bus.dREN = 1'b1;  bus.daddr = 32'h200;
        bus.ramstate = RAM_ERROR;
        @(negedge CLK);
        #2;
        total++;
        if ({bus.ramREN, bus.ramaddr, bus.dwait} !== {1'b1, 32'h200, 1'b1}) begin
            bad++;
            $display("FAIL error_cycle: got ren=%b %h d=%b want ren=1 00000200 d=1", bus.ramREN, bus.ramaddr, bus.dwait);
        end
        @(negedge CLK);
        bus.ramstate = RAM_ACCESS;
        bus.ramload  = 32'h1234;
        #2;
        total++;
        if ({bus.ramREN, bus.dwait} !== 2'b01) begin
            bad++;
            $display("FAIL error_idle: got ren=%b d=%b want ren=0 d=1", bus.ramREN, bus.dwait);
        end
        @(negedge CLK);
        #2;
        total++;
        if ({bus.ramREN, bus.dwait, bus.dload} !== {2'b10, 32'h1234}) begin
            bad++;
            $display("FAIL error_retry: got ren=%b d=%b %h want ren=1 d=0 00001234", bus.ramREN, bus.dwait, bus.dload);
        end
        clear_inputs();
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.iREN = 1'b1;  bus.iaddr = 32'h300;
        bus.ramstate = RAM_BUSY;
        @(negedge CLK);
        #2;
        total++;
        if (bus.ramREN !== 1'b1) begin
            bad++;
            $display("FAIL withdraw_grant: got ren=%b want 1", bus.ramREN);
        end
        @(negedge CLK);
        bus.iREN = 1'b0;
        #2;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait} !== 3'b001) begin
            bad++;
            $display("FAIL withdraw_drop: got %b want 001", {bus.ramREN, bus.ramWEN, bus.iwait});
        end
        // back in IDLE: a fresh request is only registered, not served
        @(negedge CLK);
        bus.iREN = 1'b1;
        bus.ramstate = RAM_ACCESS;
        #2;
        total++;
        if ({bus.ramREN, bus.iwait} !== 2'b01) begin
            bad++;
            $display("FAIL withdraw_idle: got ren=%b i=%b want ren=0 i=1", bus.ramREN, bus.iwait);
        end
        clear_inputs();
    endtask

    task automatic test_mid_reset();
        logic exp_i;
        logic exp_d;
        do_reset();
        bus.iREN = 1'b1;  bus.iaddr = 32'h700;
        bus.dREN = 1'b1;  bus.daddr = 32'h400;
        bus.ramstate = RAM_ACCESS;
        repeat (3) @(negedge CLK);
        // fourth data grant stalls on BUSY and is cut by reset
        @(negedge CLK);
        bus.ramstate = RAM_BUSY;
        nRST = 1'b0;
        #2;
        total++;
        if ({bus.ramREN, bus.dwait} !== 2'b11) begin
            bad++;
            $display("FAIL midreset_busy: got ren=%b d=%b want ren=1 d=1", bus.ramREN, bus.dwait);
        end
        @(negedge CLK);
        nRST = 1'b1;
        bus.ramstate = RAM_ACCESS;
        #2;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 4'b0011) begin
            bad++;
            $display("FAIL midreset_idle: got %b want 0011", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait});
        end
        // a cleared counter grants four more data accesses before the fetch
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            #2;
            exp_i = (c != 5);
            exp_d = (c == 5);
            total++;
            if ({bus.iwait, bus.dwait} !== {exp_i, exp_d}) begin
                bad++;
                $display("FAIL midreset_count c%0d: got i=%b d=%b want i=%b d=%b", c, bus.iwait, bus.dwait, exp_i, exp_d);
            end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int          own;      // 0 none, 1 fetch, 2 data
        int          streak;
        int          n_own;
        int          n_streak;
        int          r;
        logic        dreq;
        logic        si;
        logic        sd;
        logic        acc;
        logic [3:0]  e_ctrl;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic [31:0] e_il;
        logic [31:0] e_dl;
        do_reset();
        own    = 0;
        streak = 0;
        for (int c = 0; c < 400; c++) begin
            bus.iREN   = ($urandom_range(0, 9) < 7);
            bus.dREN   = ($urandom_range(0, 9) < 4);
            bus.dWEN   = ($urandom_range(0, 9) < 3);
            bus.iaddr  = $urandom;
            bus.daddr  = $urandom;
            bus.dstore = $urandom;
            bus.ramload = $urandom;
            r = $urandom_range(0, 19);
            if (r < 8)       bus.ramstate = RAM_ACCESS;
            else if (r < 14) bus.ramstate = RAM_BUSY;
            else if (r < 17) bus.ramstate = RAM_FREE;
            else             bus.ramstate = RAM_ERROR;
            #2;
            dreq = bus.dREN | bus.dWEN;
            si   = (own == 1) && bus.iREN;
            sd   = (own == 2) && dreq;
            acc  = (bus.ramstate == RAM_ACCESS);
            e_ctrl  = {si || (sd && !bus.dWEN), sd && bus.dWEN, !(si && acc), !(sd && acc)};
            e_addr  = si ? bus.iaddr : (sd ? bus.daddr : 32'd0);
            e_store = sd ? bus.dstore : 32'd0;
            e_il    = (si && acc) ? bus.ramload : 32'd0;
            e_dl    = (sd && acc && !bus.dWEN) ? bus.ramload : 32'd0;
            total++;
            if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== e_ctrl) begin
                bad++;
                $display("FAIL rand_ctrl c%0d: got %b want %b", c, {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, e_ctrl);
            end
            total++;
            if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== {e_addr, e_store, e_il, e_dl}) begin
                bad++;
                $display("FAIL rand_data c%0d: got %h %h %h %h want %h %h %h %h", c, bus.ramaddr, bus.ramstore,
                         bus.iload, bus.dload, e_addr, e_store, e_il, e_dl);
            end
            total++;
            if ((bus.iwait === 1'b0 && bus.dwait === 1'b0) || (bus.ramREN === 1'b1 && bus.ramWEN === 1'b1)) begin
                bad++;
                $display("FAIL rand_exclusive c%0d: got i=%b d=%b ren=%b wen=%b want no overlap", c,
                         bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN);
            end
            if (sd && acc && bus.iREN)           n_streak = (streak == LIMIT) ? LIMIT : streak + 1;
            else if ((si && acc) || !bus.iREN)   n_streak = 0;
            else                                 n_streak = streak;
            if (own == 0 || (si && acc) || (sd && acc)) begin
                if (dreq && !(bus.iREN && n_streak == LIMIT)) n_own = 2;
                else if (bus.iREN)                            n_own = 1;
                else                                          n_own = 0;
            end else if (!(si || sd) || bus.ramstate == RAM_ERROR) begin
                n_own = 0;
            end else begin
                n_own = own;
            end
            @(posedge CLK);
            own    = n_own;
            streak = n_streak;
            @(negedge CLK);
        end
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nRST  = 1'b0;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_error_retry();
        test_withdraw();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
